// File: rtl/can_bit_timing_if.sv
// Bus-side signals between the CAN bit-timing stage and its environment.
// The slave side is the bit-timing block; the master side drives rx_in and hard_sync_en.
interface can_bit_timing_if;
  logic rx_in;
  logic hard_sync_en;
  logic rx_bit;
  logic sample_point;
  logic tx_point;
  logic sync_event;

  modport master (
    output rx_in,
    output hard_sync_en,
    input  rx_bit,
    input  sample_point,
    input  tx_point,
    input  sync_event
  );

  modport slave (
    input  rx_in,
    input  hard_sync_en,
    output rx_bit,
    output sample_point,
    output tx_point,
    output sync_event
  );
endinterface

// File: rtl/can_bit_timing.sv
// CAN bit timing: tq prescaler, SYNC/TSEG1/TSEG2 segmentation, hard sync and SJW-limited resync.
// Produces the sampled bit with a sample_point strobe and a tx_point strobe at bit start.
module can_bit_timing #(
  parameter int BRP   = 1,
  parameter int TSEG1 = 3,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1,
  parameter int CW    = 8
) (
  input logic clock,
  input logic reset,
  can_bit_timing_if.slave bus
);
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } state_t;

  localparam logic [CW-1:0] BRP_LAST  = CW'(BRP - 1);
  localparam logic [CW-1:0] SEG1_LAST = CW'(TSEG1 - 1);
  localparam logic [CW-1:0] SEG2_LAST = CW'(TSEG2 - 1);
  localparam logic [CW-1:0] TSEG2_C   = CW'(TSEG2);
  localparam logic [CW-1:0] SJW_C     = CW'(SJW);
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_t        state_r, state_s;
  logic [CW-1:0] psc_r, cnt_r, ext_r, shr_r;
  logic [CW-1:0] psc_s, cnt_s, ext_s, shr_s;
  logic          sync_allowed_r, rx_prev_r, restart_r;
  logic          rx_bit_r, sample_point_r, tx_point_r, sync_event_r;
  logic          edge_s, hard_s, resync_s, tq_tick_s, seg1_done_s, seg2_done_s;

  assign bus.rx_bit       = rx_bit_r;
  assign bus.sample_point = sample_point_r;
  assign bus.tx_point     = tx_point_r;
  assign bus.sync_event   = sync_event_r;

  // Edge detection and the timing position of this cycle once any sync has been applied
  always_comb begin
    edge_s   = rx_prev_r & ~bus.rx_in;
    hard_s   = edge_s & bus.hard_sync_en;
    resync_s = edge_s & ~bus.hard_sync_en & sync_allowed_r;
    state_s  = state_r;
    psc_s    = psc_r;
    cnt_s    = cnt_r;
    ext_s    = ext_r;
    shr_s    = shr_r;
    if (hard_s) begin
      state_s = ST_SYNC;
      psc_s   = ZERO_C;
      cnt_s   = ZERO_C;
      ext_s   = ZERO_C;
      shr_s   = ZERO_C;
    end else if (resync_s) begin
      case (state_r)
        ST_TSEG1: ext_s = ((cnt_r + ONE_C) < SJW_C) ? (cnt_r + ONE_C) : SJW_C;
        ST_TSEG2: begin
          // Edge close enough to the bit end: the current tq is already the next SYNC
          if ((TSEG2_C - cnt_r) <= SJW_C) begin
            state_s = ST_SYNC;
            psc_s   = ZERO_C;
            cnt_s   = ZERO_C;
            ext_s   = ZERO_C;
            shr_s   = ZERO_C;
          end else begin
            shr_s = SJW_C;
          end
        end
        default: ext_s = ext_r;
      endcase
    end else begin
      state_s = state_r;
    end
    tq_tick_s   = (psc_s == BRP_LAST);
    seg1_done_s = tq_tick_s && (state_s == ST_TSEG1) && (cnt_s == (SEG1_LAST + ext_s));
    seg2_done_s = tq_tick_s && (state_s == ST_TSEG2) && (cnt_s == (SEG2_LAST - shr_s));
  end

  // Segment FSM, prescaler and registered strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r        <= ST_SYNC;
      psc_r          <= ZERO_C;
      cnt_r          <= ZERO_C;
      ext_r          <= ZERO_C;
      shr_r          <= ZERO_C;
      sync_allowed_r <= 1'b1;
      rx_prev_r      <= 1'b1;
      restart_r      <= 1'b1;
      rx_bit_r       <= 1'b1;
      sample_point_r <= 1'b0;
      tx_point_r     <= 1'b0;
      sync_event_r   <= 1'b0;
    end else if (restart_r) begin
      // First clock after release: hold SYNC so the next cycle is a fresh bit start
      restart_r      <= 1'b0;
      rx_prev_r      <= bus.rx_in;
      sample_point_r <= 1'b0;
      tx_point_r     <= 1'b1;
      sync_event_r   <= 1'b0;
    end else begin
      rx_prev_r      <= bus.rx_in;
      sync_event_r   <= hard_s | resync_s;
      sample_point_r <= seg1_done_s;
      tx_point_r     <= seg2_done_s;
      psc_r          <= tq_tick_s ? ZERO_C : (psc_s + ONE_C);
      if (seg1_done_s) begin
        rx_bit_r       <= bus.rx_in;
        sync_allowed_r <= 1'b1;
      end else if (hard_s | resync_s) begin
        sync_allowed_r <= 1'b0;
      end
      case (state_s)
        ST_SYNC: begin
          ext_r   <= ZERO_C;
          shr_r   <= ZERO_C;
          cnt_r   <= ZERO_C;
          state_r <= tq_tick_s ? ST_TSEG1 : ST_SYNC;
        end
        ST_TSEG1: begin
          ext_r <= ext_s;
          shr_r <= shr_s;
          if (seg1_done_s) begin
            state_r <= ST_TSEG2;
            cnt_r   <= ZERO_C;
          end else begin
            state_r <= ST_TSEG1;
            cnt_r   <= tq_tick_s ? (cnt_s + ONE_C) : cnt_s;
          end
        end
        ST_TSEG2: begin
          ext_r <= ext_s;
          shr_r <= shr_s;
          if (seg2_done_s) begin
            state_r <= ST_SYNC;
            cnt_r   <= ZERO_C;
          end else begin
            state_r <= ST_TSEG2;
            cnt_r   <= tq_tick_s ? (cnt_s + ONE_C) : cnt_s;
          end
        end
        default: begin
          state_r <= ST_SYNC;
          cnt_r   <= ZERO_C;
          ext_r   <= ZERO_C;
          shr_r   <= ZERO_C;
        end
      endcase
    end
  end
endmodule
